// File: rtl/spi_master_pkg.sv
// Shared SPI definitions: FSM states, mode encodings and transfer geometry.
// The slave imports the same mode constants so both ends agree on {CPOL,CPHA}.
package spi_master_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } spi_state_e;

   localparam logic [1:0] MODE0 = 2'd0;
   localparam logic [1:0] MODE1 = 2'd1;
   localparam logic [1:0] MODE2 = 2'd2;
   localparam logic [1:0] MODE3 = 2'd3;

   localparam int SPI_BITS  = 8;
   localparam int SPI_EDGES = 16;

endpackage

// File: rtl/spi_master_clk_div.sv
// Enable-gated half-period counter; tick pulses on the last clk cycle of each
// SCLK half-period and the count restarts from zero whenever en is low.
module spi_master_clk_div #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam logic [7:0] TERM = 8'(CLK_DIV - 1);

   logic [7:0] cnt_q;
   logic [7:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q + 8'd1;
      if (!en || (cnt_q == TERM)) begin
         cnt_d = 8'd0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= 8'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick = en && (cnt_q == TERM);

endmodule

// File: rtl/spi_master.sv
// Single-clock SPI master: one 8-bit full-duplex transfer per accepted start.
// SCLK is a registered data output toggled on divider ticks, never a clock.
module spi_master
   import spi_master_pkg::*;
#(
   parameter logic [1:0] mode    = 2'd3,
   parameter int         CLK_DIV = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [SPI_BITS-1:0] data_in,
   input  logic                MISO,
   output logic                MOSI,
   output logic                SCLK,
   output logic                CS,
   output logic                busy,
   output logic                done,
   output logic [SPI_BITS-1:0] rx
);

   localparam logic       CPOL      = mode[1];
   localparam logic       CPHA      = mode[0];
   localparam logic [4:0] EDGE_LAST = 5'(SPI_EDGES);

   spi_state_e          state_q;
   logic                sclk_q;
   logic                cs_q;
   logic                mosi_q;
   logic                busy_q;
   logic                done_q;
   logic [SPI_BITS-1:0] rx_q;
   logic [SPI_BITS-1:0] tx_sh_q;
   logic [SPI_BITS-1:0] rx_sh_q;
   logic [4:0]          edge_q;
   logic [4:0]          edge_d;

   logic tick;
   logic lead_edge;
   logic sample_edge;
   logic shift_edge;

   spi_master_clk_div #(
      .CLK_DIV (CLK_DIV)
   ) u_clk_div (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (state_q != IDLE),
      .tick  (tick)
   );

   // edge_d is the number of the SCLK edge issued on this tick; odd = leading.
   assign edge_d      = edge_q + 5'd1;
   assign lead_edge   = edge_d[0];
   assign sample_edge = CPHA ? ~lead_edge : lead_edge;
   assign shift_edge  = CPHA ? lead_edge : (~lead_edge && (edge_d != EDGE_LAST));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         sclk_q  <= CPOL;
         cs_q    <= 1'b1;
         mosi_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         rx_q    <= '0;
         tx_sh_q <= '0;
         rx_sh_q <= '0;
         edge_q  <= 5'd0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q <= SETUP;
                  cs_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  rx_sh_q <= '0;
                  edge_q  <= 5'd0;
                  // CPHA=0 must present the MSB before the first edge, so it is
                  // consumed here and the shifter holds the remaining bits.
                  if (CPHA) begin
                     tx_sh_q <= data_in;
                     mosi_q  <= 1'b0;
                  end else begin
                     tx_sh_q <= {data_in[SPI_BITS-2:0], 1'b0};
                     mosi_q  <= data_in[SPI_BITS-1];
                  end
               end
            end
            SETUP: begin
               if (tick) begin
                  state_q <= XFER;
               end
            end
            XFER: begin
               if (tick) begin
                  sclk_q <= ~sclk_q;
                  edge_q <= edge_d;
                  if (sample_edge) begin
                     rx_sh_q <= {rx_sh_q[SPI_BITS-2:0], MISO};
                  end
                  if (shift_edge) begin
                     mosi_q  <= tx_sh_q[SPI_BITS-1];
                     tx_sh_q <= {tx_sh_q[SPI_BITS-2:0], 1'b0};
                  end
                  if (edge_d == EDGE_LAST) begin
                     sclk_q  <= CPOL;
                     edge_q  <= 5'd0;
                     state_q <= HOLD;
                  end
               end
            end
            HOLD: begin
               if (tick) begin
                  state_q <= IDLE;
                  cs_q    <= 1'b1;
                  busy_q  <= 1'b0;
                  rx_q    <= rx_sh_q;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign MOSI = mosi_q;
   assign SCLK = sclk_q;
   assign CS   = cs_q;
   assign busy = busy_q;
   assign done = done_q;
   assign rx   = rx_q;

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master: five instances covering modes 0..3 at CLK_DIV=4
// and mode 0 at CLK_DIV=1; instance 0 talks to a behavioural mode-0 slave.
module tb_spi_master;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n;
   logic [4:0] start;
   logic [4:0] miso;
   logic [4:0] mosi;
   logic [4:0] sclk;
   logic [4:0] cs;
   logic [4:0] busy;
   logic [4:0] done;
   logic [7:0] din [5];
   logic [7:0] rxv [5];

   int cyc = 0;
   int total = 0;
   int bad = 0;
   int dcnt [5] = '{default: 0};
   int sedge [5] = '{default: 0};
   logic [4:0] sclk_prev = 5'd0;

   // idx 0..3: mode idx, CLK_DIV=4; idx 4: mode 0, CLK_DIV=1
   for (genvar g = 0; g < 5; g++) begin : g_dut
      spi_master #(
         .mode    ((g == 4) ? 2'd0 : 2'(g)),
         .CLK_DIV ((g == 4) ? 1 : 4)
      ) u_dut (
         .clk     (clk),
         .rst_n   (rst_n),
         .start   (start[g]),
         .data_in (din[g]),
         .MISO    (miso[g]),
         .MOSI    (mosi[g]),
         .SCLK    (sclk[g]),
         .CS      (cs[g]),
         .busy    (busy[g]),
         .done    (done[g]),
         .rx      (rxv[g])
      );
   end

   // Mode-0 slave: drives its MSB when selected, samples on rising SCLK,
   // shifts out on falling SCLK.
   logic [7:0] s_tx = 8'h00;
   logic [7:0] s_rx = 8'h00;
   logic       s_miso = 1'b0;
   logic       s_first = 1'b0;
   logic       first_mosi = 1'b0;

   always @(negedge cs[0]) begin
      s_tx    = 8'h3C;
      s_rx    = 8'h00;
      s_miso  = s_tx[7];
      s_first = 1'b1;
   end
   always @(posedge sclk[0]) begin
      if (!cs[0]) begin
         if (s_first) first_mosi = mosi[0];
         s_first = 1'b0;
         s_rx = {s_rx[6:0], mosi[0]};
      end
   end
   always @(negedge sclk[0]) begin
      if (!cs[0]) begin
         s_tx   = {s_tx[6:0], 1'b0};
         s_miso = s_tx[7];
      end
   end

   assign miso = {mosi[4:1], s_miso};

   always @(posedge clk) begin
      cyc <= cyc + 1;
      sclk_prev <= sclk;
      for (int i = 0; i < 5; i++) begin
         if (done[i]) dcnt[i] <= dcnt[i] + 1;
         if (sclk[i] !== sclk_prev[i]) sedge[i] <= sedge[i] + 1;
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic pulse_start(input int i, input logic [7:0] d, output int t0);
      @(negedge clk);
      din[i]   = d;
      start[i] = 1'b1;
      t0       = cyc;
      @(negedge clk);
      start[i] = 1'b0;
   endtask

   task automatic wait_done(input int i, input int budget, output int t);
      int n;
      n = 0;
      t = -1;
      while (n < budget && t < 0) begin
         @(negedge clk);
         if (done[i]) t = cyc;
         n++;
      end
      if (t < 0) begin
         total++;
         bad++;
         $display("FAIL done_timeout idx=%0d: no done within %0d cycles", i, budget);
      end
   endtask

   task automatic wait_edges(input int i, input int base, input int n);
      int k;
      k = 0;
      while ((sedge[i] - base) < n && k < 1000) begin
         @(negedge clk);
         k++;
      end
      if (k >= 1000) begin
         total++;
         bad++;
         $display("FAIL edge_timeout idx=%0d: saw %0d edges want %0d", i, sedge[i] - base, n);
      end
   endtask

   initial begin
      int t0, t, t1, t2, e0, d0;
      rst_n = 1'b0;
      start = 5'd0;
      for (int i = 0; i < 5; i++) din[i] = 8'h00;
      repeat (3) @(negedge clk);

      check("rst_cs", cs, 5'b11111);
      check("rst_sclk", sclk, 5'b01100);
      check("rst_mosi", mosi, 5'd0);
      check("rst_busy", busy, 5'd0);
      check("rst_done", done, 5'd0);
      check("rst_rx", rxv[3], 8'h00);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_cs", cs, 5'b11111);

      // 1: mode 3, loopback A5
      e0 = sedge[3];
      pulse_start(3, 8'hA5, t0);
      check("t1_cs_low", cs[3], 1'b0);
      check("t1_busy", busy[3], 1'b1);
      wait_done(3, 200, t);
      check("t1_latency", t - t0, 73);
      check("t1_rx", rxv[3], 8'hA5);
      check("t1_edges", sedge[3] - e0, 16);
      check("t1_sclk_idle", sclk[3], 1'b1);
      check("t1_cs_high", cs[3], 1'b1);
      check("t1_busy_low", busy[3], 1'b0);
      @(negedge clk);
      check("t1_done_width", done[3], 1'b0);

      // 2: mode 0 against slave model
      pulse_start(0, 8'hC3, t0);
      wait_done(0, 200, t);
      check("t2_slave_rx", s_rx, 8'hC3);
      check("t2_rx", rxv[0], 8'h3C);
      check("t2_first_mosi", first_mosi, 1'b1);
      check("t2_sclk_idle", sclk[0], 1'b0);

      // 3: modes 1 and 2, loopback 81
      for (int i = 1; i <= 2; i++) begin
         check($sformatf("t3_idle_pre_m%0d", i), sclk[i], (i == 2) ? 1'b1 : 1'b0);
         pulse_start(i, 8'h81, t0);
         wait_done(i, 200, t);
         check($sformatf("t3_rx_m%0d", i), rxv[i], 8'h81);
         check($sformatf("t3_idle_post_m%0d", i), sclk[i], (i == 2) ? 1'b1 : 1'b0);
      end

      // 4: start while busy is ignored
      e0 = sedge[3];
      pulse_start(3, 8'h00, t0);
      d0 = dcnt[3];
      wait_edges(3, e0, 6);
      @(negedge clk);
      din[3]   = 8'hFF;
      start[3] = 1'b1;
      @(negedge clk);
      start[3] = 1'b0;
      wait_done(3, 200, t);
      check("t4_rx", rxv[3], 8'h00);
      check("t4_latency", t - t0, 73);
      repeat (5) @(negedge clk);
      check("t4_one_done", dcnt[3] - d0, 1);
      check("t4_cs_idle", cs[3], 1'b1);
      check("t4_busy_idle", busy[3], 1'b0);

      // 5: reset mid-transfer
      e0 = sedge[3];
      pulse_start(3, 8'hC3, t0);
      wait_edges(3, e0, 9);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("t5_cs", cs[3], 1'b1);
      check("t5_sclk", sclk[3], 1'b1);
      check("t5_busy", busy[3], 1'b0);
      check("t5_rx", rxv[3], 8'h00);
      d0 = dcnt[3];
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (80) @(negedge clk);
      check("t5_no_done", dcnt[3] - d0, 0);
      pulse_start(3, 8'h5A, t0);
      wait_done(3, 200, t);
      check("t5_rx_after", rxv[3], 8'h5A);

      // 6: CLK_DIV=1, start held high for back-to-back transfers
      @(negedge clk);
      din[4]   = 8'h3C;
      start[4] = 1'b1;
      t0       = cyc;
      wait_done(4, 60, t1);
      check("t6_latency", t1 - t0, 19);
      check("t6_rx1", rxv[4], 8'h3C);
      check("t6_cs_gap", cs[4], 1'b1);
      @(negedge clk);
      check("t6_cs_relow", cs[4], 1'b0);
      check("t6_busy2", busy[4], 1'b1);
      start[4] = 1'b0;
      wait_done(4, 60, t2);
      check("t6_spacing", t2 - t1, 19);
      check("t6_rx2", rxv[4], 8'h3C);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
